rom_pair_streamer: RTL and testbench
====================================

ROM_PAIR_STREAMER -- requirements
Module: rom_pair_streamer

Interface
REQ-001 Parameter IMG_W, default 64, image width in pixels (power of two).
REQ-002 Parameter IMG_H, default 64, image height in pixels.
REQ-003 Parameter ADDR_W, default 12, ROM address width; SHALL equal log2(IMG_W*IMG_H).
REQ-004 Parameter DATA_W, default 13, ROM word/pixel width.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to stream one full frame.
REQ-008 abort  in  1  synchronous frame cancel.
REQ-009 busy  out  1  high from accepted start until done pulse or abort.
REQ-010 done  out  1  one-cycle pulse after final pair accepted.
REQ-011 rom_addr1  out  ADDR_W  dual-port ROM port-1 address (even pixel).
REQ-012 rom_addr2  out  ADDR_W  dual-port ROM port-2 address (odd pixel).
REQ-013 rom_data1  in  DATA_W  ROM port-1 data, combinational from rom_addr1.
REQ-014 rom_data2  in  DATA_W  ROM port-2 data, combinational from rom_addr2.
REQ-015 out_valid  out  1  output pair valid.
REQ-016 out_ready  in  1  downstream accepts pair.
REQ-017 out_pix0 / out_pix1  out  DATA_W each  pixels at even / odd address.
REQ-018 out_last  out  1  marks final pair of frame.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, DRAIN; DONE state asserts done for exactly one cycle then returns to IDLE.
REQ-020 IDLE + start: pointer ptr<=0, go FETCH, busy<=1 next cycle; start while busy SHALL be ignored.
REQ-021 rom_addr1 SHALL equal ptr, rom_addr2 SHALL equal ptr+1 (ADDR_W bits, no carry out) at all times; ptr is always even.
REQ-022 Output register loads {rom_data1, rom_data2} when in FETCH and (out_valid==0 or out_ready==1); ptr then advances by 2.
REQ-023 Latency: first out_valid SHALL be 2 cycles after start sampled high (1 cycle FSM, 1 cycle load).
REQ-024 Sustained throughput SHALL be one pair per cycle when out_ready held high; total IMG_W*IMG_H/2 pairs (2048 default).
REQ-025 While out_valid && !out_ready, out_pix0/out_pix1/out_last SHALL hold stable and ptr SHALL not advance.
REQ-026 Load at ptr == IMG_W*IMG_H-2 sets out_last and moves FSM to DRAIN; no ptr wrap to 0 is ever issued as a fetch.
REQ-027 DRAIN: on out_valid && out_ready && out_last go DONE; out_valid clears same edge.
REQ-028 abort (any non-IDLE state) SHALL next-edge clear out_valid, out_last, busy, ptr, return to IDLE, no done pulse; abort wins over start and over handshake in same cycle.
REQ-029 abort in IDLE SHALL have no effect.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, ptr 0, busy 0, done 0, out_valid 0, out_last 0, out_pix0 0, out_pix1 0.
REQ-031 Reset mid-frame SHALL discard the frame; a fresh start after release restarts from address 0.

Configuration
REQ-032 Macro ROM_PAIR_STREAMER_EOL_EN: when defined, output out_eol (1 bit) SHALL be registered alongside each pair, high when the pair contains column IMG_W-1 (ptr mod IMG_W == IMG_W-2), reset 0, held under backpressure.
REQ-033 Without ROM_PAIR_STREAMER_EOL_EN, port out_eol SHALL not exist and behaviour is otherwise identical.

Structure
REQ-034 Shared package SHALL hold IMG_W/IMG_H/ADDR_W/DATA_W defaults, the FSM state enum, and the frame pair count constant.
REQ-035 One sub-module, pair_out_reg (valid/ready output register with hold), is natural; FSM and pointer stay in top.

Verification
REQ-036 Reset, start at cycle 0, out_ready=1 -> out_valid at cycle 2, pairs (mem[0],mem[1]) .. (mem[4094],mem[4095]), 2048 consecutive beats, out_last only on beat 2048, done one cycle after.
REQ-037 Random out_ready (50%) -> every pair delivered exactly once in order, outputs stable during stalls, rom_addr1 never odd.
REQ-038 out_ready=0 while last pair valid for 10 cycles -> state DRAIN, busy=1, no done until ready asserted.
REQ-039 abort at beat 100 with start also high -> next cycle out_valid=0, busy=0, no done; following start restarts at address 0.
REQ-040 rst_n low at beat 500 (asynchronous, mid-cycle) -> all outputs 0 immediately; start while busy at beat 10 -> ignored, stream unaffected.
REQ-041 With ROM_PAIR_STREAMER_EOL_EN -> out_eol high on beats 32, 64, ..., 2048 only (IMG_W=64).

Source files
------------

// File: rtl/rom_pair_streamer_pkg.sv
// Shared definitions for the ROM pair streamer: default geometry, the
// controller state encoding and the number of pixel pairs in one frame.
package rom_pair_streamer_pkg;

    localparam int IMG_W_DEF  = 64;
    localparam int IMG_H_DEF  = 64;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 13;

    // Two pixels per beat, so a default frame is 64*64/2 = 2048 beats.
    localparam int FRAME_PAIRS = IMG_W_DEF * IMG_H_DEF / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_pair_streamer_out.sv
// pair_out_reg: single-entry valid/ready output register for one pixel pair.
// Data holds while valid is high and ready is low; 'clear' drops the pair.
// Optional end-of-line flag is present when ROM_PAIR_STREAMER_EOL_EN is defined.
module pair_out_reg #(
    parameter int DATA_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] pix0_i,
    input  logic [DATA_W-1:0] pix1_i,
    input  logic              last_i,
`ifdef ROM_PAIR_STREAMER_EOL_EN
    input  logic              eol_i,
    output logic              eol_o,
`endif
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] pix0_o,
    output logic [DATA_W-1:0] pix1_o,
    output logic              last_o
);

    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic [DATA_W-1:0] pix0_q,  pix0_d;
    logic [DATA_W-1:0] pix1_q,  pix1_d;
`ifdef ROM_PAIR_STREAMER_EOL_EN
    logic              eol_q,   eol_d;
`endif

    // Next-state: clear beats load, load beats a plain drain.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        pix0_d  = pix0_q;
        pix1_d  = pix1_q;
`ifdef ROM_PAIR_STREAMER_EOL_EN
        eol_d   = eol_q;
`endif
        if (clear_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
`ifdef ROM_PAIR_STREAMER_EOL_EN
            eol_d   = 1'b0;
`endif
        end else if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            pix0_d  = pix0_i;
            pix1_d  = pix1_i;
`ifdef ROM_PAIR_STREAMER_EOL_EN
            eol_d   = eol_i;
`endif
        end else if (ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
`ifdef ROM_PAIR_STREAMER_EOL_EN
            eol_d   = 1'b0;
`endif
        end
    end

    // Output register state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            pix0_q  <= '0;
            pix1_q  <= '0;
`ifdef ROM_PAIR_STREAMER_EOL_EN
            eol_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            pix0_q  <= pix0_d;
            pix1_q  <= pix1_d;
`ifdef ROM_PAIR_STREAMER_EOL_EN
            eol_q   <= eol_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign pix0_o  = pix0_q;
    assign pix1_o  = pix1_q;
`ifdef ROM_PAIR_STREAMER_EOL_EN
    assign eol_o   = eol_q;
`endif

endmodule

// File: rtl/rom_pair_streamer.sv
// rom_pair_streamer: walks a dual-port combinational ROM two pixels at a time
// (even address on port 1, odd on port 2) and streams the pairs out over a
// valid/ready interface, one full frame per start request.
// Optional feature macro: ROM_PAIR_STREAMER_EOL_EN adds the out_eol flag.
module rom_pair_streamer
    import rom_pair_streamer_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr1,
    output logic [ADDR_W-1:0] rom_addr2,
    input  logic [DATA_W-1:0] rom_data1,
    input  logic [DATA_W-1:0] rom_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pix0,
    output logic [DATA_W-1:0] out_pix1,
`ifdef ROM_PAIR_STREAMER_EOL_EN
    output logic              out_eol,
`endif
    output logic              out_last
);

    // Address of the even pixel of the final pair in the frame.
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(IMG_W * IMG_H - 2);

`ifdef ROM_PAIR_STREAMER_EOL_EN
    // IMG_W is a power of two, so the column is just the low address bits.
    localparam int               COL_W    = $clog2(IMG_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 2);
    logic eol_in;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic              load;
    logic              clear;
    logic              last_in;

    // Controller: next state, pointer update and output-register control.
    // Abort in any active state takes priority over start and handshake.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        clear   = 1'b0;
        last_in = 1'b0;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            clear   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ptr_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!out_valid || out_ready) begin
                        load = 1'b1;
                        if (ptr_q == LAST_PTR) begin
                            // Final pair: hold the pointer rather than wrap to 0.
                            last_in = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            ptr_d = ptr_q + ADDR_W'(2);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Controller state and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rom_addr1 = ptr_q;
    assign rom_addr2 = ptr_q + ADDR_W'(1);
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

`ifdef ROM_PAIR_STREAMER_EOL_EN
    assign eol_in = (ptr_q[COL_W-1:0] == COL_LAST);
`endif

    pair_out_reg #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .load_i  (load),
        .pix0_i  (rom_data1),
        .pix1_i  (rom_data2),
        .last_i  (last_in),
`ifdef ROM_PAIR_STREAMER_EOL_EN
        .eol_i   (eol_in),
        .eol_o   (out_eol),
`endif
        .ready_i (out_ready),
        .valid_o (out_valid),
        .pix0_o  (out_pix0),
        .pix1_o  (out_pix1),
        .last_o  (out_last)
    );

endmodule

// File: tb/tb_rom_pair_streamer.sv
// Directed bench for rom_pair_streamer with a combinational ROM model.
module tb_rom_pair_streamer;
    import rom_pair_streamer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [11:0] rom_addr1;
    logic [11:0] rom_addr2;
    logic [12:0] rom_data1;
    logic [12:0] rom_data2;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_pix0;
    logic [12:0] out_pix1;
    logic        out_last;
`ifdef ROM_PAIR_STREAMER_EOL_EN
    logic        out_eol;
`endif

    int vectors;
    int miscompares;
    int idx;
    logic acc;

    rom_pair_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rom_addr1 (rom_addr1),
        .rom_addr2 (rom_addr2),
        .rom_data1 (rom_data1),
        .rom_data2 (rom_data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix0  (out_pix0),
        .out_pix1  (out_pix1),
`ifdef ROM_PAIR_STREAMER_EOL_EN
        .out_eol   (out_eol),
`endif
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: mem[a] = (5*a + 0x123) mod 2^13
    function automatic logic [12:0] rom_word(input logic [11:0] a);
        logic [12:0] v;
        v = {1'b0, a};
        return (v * 13'd5) + 13'h0123;
    endfunction

    assign rom_data1 = rom_word(rom_addr1);
    assign rom_data2 = rom_word(rom_addr2);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Beat b (0-based) carries mem[2b], mem[2b+1]; last only on the final beat.
    task automatic check_beat(input string tag, input int b);
        logic [11:0] a;
        logic [31:0] exp_w;
        logic [31:0] got_w;
        a     = 12'(2 * b);
        exp_w = {4'b0, 1'b1, (b == FRAME_PAIRS - 1), rom_word(a), rom_word(a + 12'd1)};
        got_w = {4'b0, out_valid, out_last, out_pix0, out_pix1};
        check_val($sformatf("%s_beat%0d", tag, b), got_w, exp_w);
`ifdef ROM_PAIR_STREAMER_EOL_EN
        check_val($sformatf("%s_eol%0d", tag, b), 32'(out_eol), 32'((b % 32) == 31));
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_busy",  32'(busy),      32'd0);
        check_val("rst_done",  32'(done),      32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_last",  32'(out_last),  32'd0);
        check_val("rst_pix0",  32'(out_pix0),  32'd0);
        check_val("rst_pix1",  32'(out_pix1),  32'd0);
        check_val("rst_addr1", 32'(rom_addr1), 32'd0);
        check_val("rst_addr2", 32'(rom_addr2), 32'd1);
        rst_n = 1'b1;
        tick();

        // Full frame, ready held high; start while busy at beat 10 is ignored
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("lat_c1_valid", 32'(out_valid), 32'd0);
        check_val("lat_c1_busy",  32'(busy),      32'd1);
        tick();
        for (int b = 0; b < FRAME_PAIRS; b++) begin
            check_beat("A", b);
            start = (b == 10);
            tick();
        end
        start = 1'b0;
        check_val("A_done",       32'(done),      32'd1);
        check_val("A_valid_post", 32'(out_valid), 32'd0);
        check_val("A_busy_post",  32'(busy),      32'd0);
        tick();
        check_val("A_done_once",  32'(done),      32'd0);

        // Random backpressure, then hold the last pair for 10 cycles
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 20000 && idx < FRAME_PAIRS - 1; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid) check_beat("B", idx);
            check_val("B_addr_even", 32'(rom_addr1[0]), 32'd0);
            acc = out_valid && out_ready;
            tick();
            if (acc) idx++;
        end
        check_val("B_reach_last", 32'(idx), 32'(FRAME_PAIRS - 1));
        out_ready = 1'b0;
        for (int w = 0; w < 4 && !out_valid; w++) tick();
        for (int h = 0; h < 10; h++) begin
            check_beat("B_hold", FRAME_PAIRS - 1);
            check_val("B_hold_busy", 32'(busy), 32'd1);
            check_val("B_hold_done", 32'(done), 32'd0);
            tick();
        end
        check_val("B_state_drain", 32'(dut.state_q), 32'(ST_DRAIN));
        out_ready = 1'b1;
        tick();
        check_val("B_done",  32'(done),      32'd1);
        check_val("B_valid", 32'(out_valid), 32'd0);
        tick();

        // Abort together with start at beat 100
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int b = 0; b < 100; b++) begin
            check_beat("C", b);
            tick();
        end
        check_beat("C", 100);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_val("C_valid", 32'(out_valid), 32'd0);
        check_val("C_busy",  32'(busy),      32'd0);
        check_val("C_done",  32'(done),      32'd0);
        check_val("C_last",  32'(out_last),  32'd0);
        check_val("C_addr1", 32'(rom_addr1), 32'd0);
        tick();
        check_val("C_no_done", 32'(done), 32'd0);
        check_val("C_idle",    32'(busy), 32'd0);
        // Abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("C_idle_abort_busy",  32'(busy),      32'd0);
        check_val("C_idle_abort_valid", 32'(out_valid), 32'd0);

        // Restart from address 0, then asynchronous reset at beat 500
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int b = 0; b < 500; b++) begin
            check_beat("D", b);
            tick();
        end
        check_beat("D", 500);
        #2 rst_n = 1'b0;
        #1;
        check_val("E_valid", 32'(out_valid), 32'd0);
        check_val("E_busy",  32'(busy),      32'd0);
        check_val("E_done",  32'(done),      32'd0);
        check_val("E_last",  32'(out_last),  32'd0);
        check_val("E_pix0",  32'(out_pix0),  32'd0);
        check_val("E_pix1",  32'(out_pix1),  32'd0);
        check_val("E_addr1", 32'(rom_addr1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_beat("F", 0);
        tick();
        check_beat("F", 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("F_abort_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
